tgmux2_sel_ctrl: RTL

//  Upstream select controller for the 2:1 transmission-gate mux. Arbitrates two synaptic

---
 rtl/tgmux2_sel_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tgmux2_sel_ctrl.sv
// Select controller for a 2:1 transmission-gate mux: queues events per channel, steers SEL,
// waits out the RC settle after a switch, then pulses VALID and acknowledges the consumed event.
module tgmux2_sel_ctrl #(
  parameter int CW         = 4,
  parameter int SETTLE_CYC = 2,
  parameter int PULSE_CYC  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          req0,
  input  logic          req1,
  output logic          sel,
  output logic          valid,
  output logic          ack0,
  output logic          ack1,
  output logic [CW-1:0] pend0,
  output logic [CW-1:0] pend1,
  output logic          ovf0,
  output logic          ovf1,
  output logic          busy
);

  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("SETTLE_CYC must be at least 1");
  end
  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("PULSE_CYC must be at least 1");
  end

  localparam int TMAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] PULSE_LD  = TW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] CMAX      = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, FIRE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          sel_nxt, valid_nxt;
  logic          ch, ch_nxt;
  logic          rr;
  logic          pick;
  logic          done;
  logic          dec0, dec1;

  // Saturating pending counter; a same-edge increment and consume cancel out.
  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
    logic [CW-1:0] r;
    r = cnt;
    if (inc && !dec && cnt != CMAX) r = cnt + 1'b1;
    else if (dec && !inc)           r = cnt - 1'b1;
    return r;
  endfunction

  function automatic logic sat_drop(input logic [CW-1:0] cnt,
                                    input logic inc, input logic dec);
    return inc && !dec && (cnt == CMAX);
  endfunction

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    sel_nxt   = sel;
    valid_nxt = valid;
    ch_nxt    = ch;
    done      = 1'b0;
    pick      = rr;
    if (pend0 != '0 && pend1 == '0)      pick = 1'b0;
    else if (pend0 == '0 && pend1 != '0) pick = 1'b1;

    case (state)
      IDLE: begin
        if (en && (pend0 != '0 || pend1 != '0)) begin
          ch_nxt = pick;
          if (pick == sel) begin
            state_nxt = FIRE;
            valid_nxt = 1'b1;
            tmr_nxt   = PULSE_LD;
          end else begin
            sel_nxt   = pick;
            state_nxt = SETTLE;
            tmr_nxt   = SETTLE_LD;
          end
        end
      end
      SETTLE: begin
        if (tmr == '0) begin
          state_nxt = FIRE;
          valid_nxt = 1'b1;
          tmr_nxt   = PULSE_LD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      FIRE: begin
        if (tmr == '0) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          done      = 1'b1;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign dec0 = done && !ch;
  assign dec1 = done && ch;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      sel   <= 1'b0;
      valid <= 1'b0;
      ch    <= 1'b0;
      rr    <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      pend0 <= '0;
      pend1 <= '0;
      ovf0  <= 1'b0;
      ovf1  <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      sel   <= sel_nxt;
      valid <= valid_nxt;
      ch    <= ch_nxt;
      ack0  <= dec0;
      ack1  <= dec1;
      if (done) rr <= ~ch;
      pend0 <= sat_step(pend0, req0, dec0);
      pend1 <= sat_step(pend1, req1, dec1);
      ovf0  <= ovf0 | sat_drop(pend0, req0, dec0);
      ovf1  <= ovf1 | sat_drop(pend1, req1, dec1);
    end
  end

endmodule
